// File: rtl/match_unit_pkg.sv
// rtl/match_unit_pkg.sv - shared state/mode types and helpers for the pattern-search unit
package match_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_FIRST = 2'b00,
        MODE_LAST  = 2'b01,
        MODE_COUNT = 2'b10
    } mode_e;

    // The reserved encoding 2'b11 behaves as FIRST.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_LAST;
            2'b10:   return MODE_COUNT;
            default: return MODE_FIRST;
        endcase
    endfunction

endpackage

// File: rtl/match_window.sv
// rtl/match_window.sv - combinational compare of LANES consecutive offsets starting at a signed base
module match_window
    import match_unit_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int PAT_W  = 8,
    parameter  int LANES  = 1,
    parameter  int OFF_W  = 8,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int POP_W  = $clog2(LANES + 1)
) (
    input  logic [DATA_W-1:0]       data,
    input  logic [DATA_W-1:0]       pattern,
    input  logic signed [OFF_W-1:0] base,
    output logic [LANES-1:0]        hit,
    output logic                    any_hit,
    output logic [LANE_W-1:0]       lo_lane,
    output logic [LANE_W-1:0]       hi_lane,
    output logic [POP_W-1:0]        pop
);

    localparam int NPOS = DATA_W - PAT_W + 1;
    // Only the low PAT_W bits of the shifted data and pattern take part in a compare.
    localparam logic [DATA_W-1:0] PMASK = ~({DATA_W{1'b1}} << PAT_W);

    // Per-lane compare; lanes whose offset falls outside 0..NPOS-1 never hit.
    always_comb begin
        int                off;
        logic [DATA_W-1:0] sh;
        hit = '0;
        for (int i = 0; i < LANES; i++) begin
            off = int'(base) + i;
            sh  = data >> off;
            hit[i] = (off >= 0) && (off < NPOS) && (((sh ^ pattern) & PMASK) == '0);
        end
    end

    // Lowest/highest hitting lane and the number of hits in this group.
    always_comb begin
        lo_lane = '0;
        hi_lane = '0;
        pop     = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (hit[i]) lo_lane = LANE_W'(i);
        end
        for (int i = 0; i < LANES; i++) begin
            if (hit[i]) hi_lane = LANE_W'(i);
            pop = pop + POP_W'(hit[i]);
        end
    end

    assign any_hit = |hit;

endmodule

// File: rtl/match_unit.sv
// rtl/match_unit.sv - multi-cycle first/last/count pattern search with pipeline stall and flush
module match_unit
    import match_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PAT_W  = 8,
    parameter int LANES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] pattern,
    input  logic [DATA_W-1:0] data,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [DATA_W-1:0] result,
    output logic              stallreq
);

    localparam int NPOS   = DATA_W - PAT_W + 1;
    localparam int NGRP   = (NPOS + LANES - 1) / LANES;
    localparam int GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int CNT_W  = $clog2(NPOS + 1);
    localparam int OFF_W  = $clog2(DATA_W + LANES) + 2;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int POP_W  = $clog2(LANES + 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic signed [OFF_W-1:0] base;
    logic [LANES-1:0]        hit;
    logic                    any_hit;
    logic [LANE_W-1:0]       lo_lane, hi_lane;
    logic [POP_W-1:0]        pop;
    logic [CNT_W-1:0]        total;
    logic                    last_grp;
    int                      hit_off;

    // Group pointer -> lowest offset of the group; LAST walks down from the top offset.
    always_comb begin
        int base_i;
        if (mode_q == MODE_LAST) base_i = NPOS - LANES - int'(grp_q) * LANES;
        else                     base_i = int'(grp_q) * LANES;
        base    = OFF_W'(base_i);
        hit_off = int'(base) + int'((mode_q == MODE_LAST) ? hi_lane : lo_lane);
    end

    match_window #(
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W),
        .LANES  (LANES),
        .OFF_W  (OFF_W)
    ) u_window (
        .data    (data_q),
        .pattern (pat_q),
        .base    (base),
        .hit     (hit),
        .any_hit (any_hit),
        .lo_lane (lo_lane),
        .hi_lane (hi_lane),
        .pop     (pop)
    );

    assign total    = cnt_q + CNT_W'(pop);
    assign last_grp = (grp_q == GRP_W'(NGRP - 1));

    // Next-state: accept in IDLE, one group per SCAN cycle, DONE always returns to IDLE.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        pat_d    = pat_q;
        data_d   = data_q;
        grp_d    = grp_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        found_d  = found_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d = S_SCAN;
                    mode_d  = decode_mode(mode);
                    pat_d   = pattern;
                    data_d  = data;
                    grp_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_SCAN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    grp_d = grp_q + GRP_W'(1);
                    if (mode_q == MODE_COUNT) begin
                        cnt_d = total;
                        if (last_grp) begin
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                            result_d = DATA_W'(total);
                            found_d  = (total != '0);
                        end
                    end else if (any_hit) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = DATA_W'(hit_off);
                        found_d  = 1'b1;
                    end else if (last_grp) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = '1;
                        found_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_FIRST;
            pat_q    <= '0;
            data_q   <= '0;
            grp_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            pat_q    <= pat_d;
            data_q   <= data_d;
            grp_q    <= grp_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            found_q  <= found_d;
            result_q <= result_d;
        end
    end

    assign busy     = (state_q == S_SCAN);
    assign done     = done_q;
    assign found    = found_q;
    assign result   = result_q;
    assign stallreq = !rst && (((state_q == S_IDLE) && start && !flush) || busy);

endmodule

// File: tb/tb_match_unit.sv
// tb/tb_match_unit.sv - self-checking bench for match_unit with LANES=1 and LANES=4 instances
module tb_match_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] pattern = '0, data = '0;
    logic        flush = 1'b0;

    logic        busy1, done1, found1, stall1;
    logic [31:0] result1;
    logic        busy4, done4, found4, stall4;
    logic [31:0] result4;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_res1 = '0, last_res4 = '0;
    logic        last_fnd1 = 1'b0, last_fnd4 = 1'b0;

    always #5 clk = ~clk;

    match_unit #(.DATA_W(32), .PAT_W(8), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .pattern(pattern), .data(data),
        .flush(flush), .busy(busy1), .done(done1), .found(found1), .result(result1),
        .stallreq(stall1)
    );

    match_unit #(.DATA_W(32), .PAT_W(8), .LANES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode), .pattern(pattern), .data(data),
        .flush(flush), .busy(busy4), .done(done4), .found(found4), .result(result4),
        .stallreq(stall4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: enumerate every offset, then derive answer and latency from group arithmetic.
    task automatic model(input int md, input logic [31:0] pat, input logic [31:0] dat, input int lanes,
                         output logic [31:0] res, output logic fnd, output int lat);
        int npos, ngrp, first, last, cnt;
        npos = 25;
        ngrp = (npos + lanes - 1) / lanes;
        first = -1; last = -1; cnt = 0;
        for (int p = 0; p < npos; p++) begin
            if (((dat >> p) & 32'hFF) == {24'h0, pat[7:0]}) begin
                if (first < 0) first = p;
                last = p;
                cnt++;
            end
        end
        if (md == 2) begin
            res = cnt; fnd = (cnt != 0); lat = ngrp;
        end else if (md == 1) begin
            if (last >= 0) begin res = last; fnd = 1'b1; lat = (npos - 1 - last) / lanes + 1; end
            else begin res = '1; fnd = 1'b0; lat = ngrp; end
        end else begin
            if (first >= 0) begin res = first; fnd = 1'b1; lat = first / lanes + 1; end
            else begin res = '1; fnd = 1'b0; lat = ngrp; end
        end
    endtask

    task automatic run_op(input int md, input logic [31:0] pat, input logic [31:0] dat, input bit hold);
        logic [31:0] er1, er4;
        logic        ef1, ef4;
        int          el1, el4, lat1, lat4, np1, np4, nst;
        model(md, pat, dat, 1, er1, ef1, el1);
        model(md, pat, dat, 4, er4, ef4, el4);
        @(negedge clk);
        mode = md[1:0]; pattern = pat; data = dat; start1 = 1'b1; start4 = 1'b1;
        #1 chk("stall_on_issue", {31'b0, stall1}, 32'd1);
        @(posedge clk); #1;
        if (!hold) begin start1 = 1'b0; start4 = 1'b0; end
        chk("busy_after_accept", {31'b0, busy1}, 32'd1);
        lat1 = -1; lat4 = -1; np1 = 0; np4 = 0; nst = (stall1 ? 1 : 0);
        for (int n = 1; n <= 28; n++) begin
            @(posedge clk); #1;
            if (stall1 && lat1 < 0) nst++;
            if (done1) begin np1++; if (lat1 < 0) lat1 = n; end
            if (done4) begin np4++; if (lat4 < 0) lat4 = n; end
            if (hold && lat1 >= 0 && n == lat1 + 1) start1 = 1'b0;
            if (hold && lat4 >= 0 && n == lat4 + 1) start4 = 1'b0;
        end
        start1 = 1'b0; start4 = 1'b0;
        chk("latency_l1", lat1, el1);
        chk("latency_l4", lat4, el4);
        chk("pulses_l1", np1, 1);
        chk("pulses_l4", np4, 1);
        chk("stall_cycles_l1", nst, el1);
        chk("result_l1", result1, er1);
        chk("found_l1", {31'b0, found1}, {31'b0, ef1});
        chk("result_l4", result4, er4);
        chk("found_l4", {31'b0, found4}, {31'b0, ef4});
        last_res1 = er1; last_fnd1 = ef1; last_res4 = er4; last_fnd4 = ef4;
    endtask

    initial begin
        int          md, p, np;
        logic [31:0] pat, dat;

        #2 rst = 1'b1;
        #2;
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_done", {31'b0, done1}, 32'd0);
        chk("rst_found", {31'b0, found1}, 32'd0);
        chk("rst_result", result1, 32'd0);
        chk("rst_stall", {31'b0, stall1}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_op(0, 32'hAB, 32'h00AB0000, 1'b0);
        run_op(1, 32'h01, 32'h01010101, 1'b0);
        run_op(2, 32'h01, 32'h01010101, 1'b0);
        run_op(0, 32'hFF, 32'h00000000, 1'b0);
        run_op(2, 32'hFF, 32'h00000000, 1'b0);
        run_op(3, 32'hAB, 32'h00AB0000, 1'b0);
        run_op(1, 32'h12345600, 32'h00000000, 1'b0);
        run_op(0, 32'hAB, 32'hAB000000, 1'b1);

        for (int i = 0; i < 16; i++) begin
            md  = $urandom_range(0, 3);
            pat = $urandom;
            dat = $urandom;
            case ($urandom_range(0, 2))
                0: begin p = $urandom_range(0, 24); dat[p +: 8] = pat[7:0]; end
                1: begin pat = $urandom_range(0, 3); dat = {16{pat[1:0]}}; end
                default: ;
            endcase
            run_op(md, pat, dat, 1'b0);
        end

        // Flush mid-scan: no done, results keep their previous values.
        @(negedge clk);
        mode = 2'b00; pattern = 32'hFF; data = 32'h0; start1 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        np = 0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            if (done1 || done4) np++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy_l1", {31'b0, busy1}, 32'd0);
        chk("flush_busy_l4", {31'b0, busy4}, 32'd0);
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done1 || done4) np++;
        end
        chk("flush_no_done", np, 0);
        chk("flush_result_l1", result1, last_res1);
        chk("flush_found_l1", {31'b0, found1}, {31'b0, last_fnd1});
        chk("flush_result_l4", result4, last_res4);
        chk("flush_found_l4", {31'b0, found4}, {31'b0, last_fnd4});

        // Flush beats start in IDLE.
        @(negedge clk);
        start1 = 1'b1; start4 = 1'b1; flush = 1'b1;
        #1 chk("flush_vs_start_stall", {31'b0, stall1}, 32'd0);
        @(posedge clk); #1;
        chk("flush_vs_start_busy", {31'b0, busy1}, 32'd0);
        start1 = 1'b0; start4 = 1'b0; flush = 1'b0;

        // Async reset mid-scan after a successful search.
        run_op(0, 32'hAB, 32'h00AB0000, 1'b0);
        @(negedge clk);
        mode = 2'b00; pattern = 32'hFF; data = 32'h0; start1 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy_l1", {31'b0, busy1}, 32'd0);
        chk("arst_stall_l1", {31'b0, stall1}, 32'd0);
        chk("arst_done_l1", {31'b0, done1}, 32'd0);
        chk("arst_found_l1", {31'b0, found1}, 32'd0);
        chk("arst_result_l1", result1, 32'd0);
        chk("arst_busy_l4", {31'b0, busy4}, 32'd0);
        chk("arst_result_l4", result4, 32'd0);
        @(negedge clk) rst = 1'b0;
        last_res1 = '0; last_fnd1 = 1'b0; last_res4 = '0; last_fnd4 = 1'b0;
        run_op(1, 32'h01, 32'h01010101, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
